// File: rtl/fx2_fifo_responder.sv
// Device-side model of the FX2 synchronous slave-FIFO: EP2 OUT (host->master) and
// EP6 IN (master->host) FIFOs with packet commit, ZLP counting and sticky error flags.
module fx2_fifo_responder #(
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned PKT_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fx2_slcs_n,
  input  logic        fx2_slrd_n,
  input  logic        fx2_slwr_n,
  input  logic        fx2_sloe_n,
  input  logic        fx2_pktend_n,
  input  logic [1:0]  fx2_a,
  input  logic [15:0] fx2_db_in,
  output logic [15:0] fx2_db_out,
  output logic        fx2_db_oe,
  output logic        fx2_flaga,
  output logic        fx2_flagb,
  output logic        fx2_flagc,
  output logic        fx2_flagd,
  input  logic        host_out_valid,
  output logic        host_out_ready,
  input  logic [15:0] host_out_data,
  output logic        host_in_valid,
  input  logic        host_in_ready,
  output logic [15:0] host_in_data,
  output logic [15:0] pkt_count,
  output logic [7:0]  zlp_count,
  output logic [2:0]  err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // EP2 OUT FIFO state
  logic [15:0]   ep2_mem [DEPTH];
  logic [AW-1:0] ep2_wr_ptr;
  logic [AW-1:0] ep2_rd_ptr;
  logic [CW-1:0] ep2_count;

  // EP6 IN FIFO state; ep6_count covers committed plus uncommitted words
  logic [15:0]   ep6_mem [DEPTH];
  logic [AW-1:0] ep6_wr_ptr;
  logic [AW-1:0] ep6_rd_ptr;
  logic [CW-1:0] ep6_count;
  logic [CW-1:0] ep6_committed;
  logic [CW-1:0] ep6_uncommitted;

  logic          sel;
  logic          addr_ep2;
  logic          addr_ep6;
  logic          ep2_rd_req;
  logic          ep6_wr_req;
  logic          ep6_end_req;
  logic          proto_err;
  logic          ep2_empty;
  logic          ep2_full;
  logic          ep6_empty;
  logic          ep6_full;
  logic          ep2_push;
  logic          ep2_pop;
  logic          ep6_push;
  logic          ep6_pop;
  logic [CW-1:0] unc_after;
  logic          ep6_commit;
  logic          ep6_zlp;

  // Strobe qualification and address decode
  always_comb begin
    sel         = !fx2_slcs_n;
    addr_ep2    = (fx2_a == 2'b00);
    addr_ep6    = (fx2_a == 2'b10);
    ep2_rd_req  = sel && !fx2_slrd_n && addr_ep2;
    ep6_wr_req  = sel && !fx2_slwr_n && addr_ep6;
    ep6_end_req = sel && !fx2_pktend_n && addr_ep6;
    proto_err   = sel && ((!fx2_slrd_n && !addr_ep2) ||
                          (!fx2_slwr_n && !addr_ep6) ||
                          (!fx2_pktend_n && !addr_ep6));
  end

  // Occupancy, transfer enables and commit decision
  always_comb begin
    ep2_empty  = (ep2_count == '0);
    ep2_full   = (ep2_count == CW'(DEPTH));
    ep6_empty  = (ep6_count == '0);
    ep6_full   = (ep6_count == CW'(DEPTH));
    ep2_push   = host_out_valid && !ep2_full;
    ep2_pop    = ep2_rd_req && !ep2_empty;
    ep6_push   = ep6_wr_req && !ep6_full;
    ep6_pop    = host_in_valid && host_in_ready;
    // A same-edge write is counted before the pktend decides commit vs ZLP
    unc_after  = ep6_uncommitted + CW'(ep6_push);
    ep6_commit = (ep6_end_req && (unc_after != '0)) || (unc_after == CW'(PKT_WORDS));
    ep6_zlp    = ep6_end_req && (unc_after == '0);
  end

  // Flags and handshakes are combinational from registered state
  assign fx2_db_oe      = sel && !fx2_sloe_n && addr_ep2;
  assign fx2_db_out     = ep2_empty ? 16'h0000 : ep2_mem[ep2_rd_ptr];
  assign fx2_flaga      = !ep2_empty;
  assign fx2_flagb      = !ep6_full;
  assign fx2_flagc      = !ep2_full;
  assign fx2_flagd      = !ep6_empty;
  assign host_out_ready = !ep2_full;
  assign host_in_valid  = (ep6_committed != '0);
  assign host_in_data   = host_in_valid ? ep6_mem[ep6_rd_ptr] : 16'h0000;

  // Storage arrays carry no reset; occupancy counters gate every read
  always_ff @(posedge clk) begin
    if (ep2_push) ep2_mem[ep2_wr_ptr] <= host_out_data;
    if (ep6_push) ep6_mem[ep6_wr_ptr] <= fx2_db_in;
  end

  // EP2 pointers and count
  always_ff @(posedge clk) begin
    if (rst) begin
      ep2_wr_ptr <= '0;
      ep2_rd_ptr <= '0;
      ep2_count  <= '0;
    end else begin
      if (ep2_push) ep2_wr_ptr <= ep2_wr_ptr + AW'(1);
      if (ep2_pop)  ep2_rd_ptr <= ep2_rd_ptr + AW'(1);
      ep2_count <= ep2_count + CW'(ep2_push) - CW'(ep2_pop);
    end
  end

  // EP6 pointers, counts and commit bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      ep6_wr_ptr      <= '0;
      ep6_rd_ptr      <= '0;
      ep6_count       <= '0;
      ep6_committed   <= '0;
      ep6_uncommitted <= '0;
    end else begin
      if (ep6_push) ep6_wr_ptr <= ep6_wr_ptr + AW'(1);
      if (ep6_pop)  ep6_rd_ptr <= ep6_rd_ptr + AW'(1);
      ep6_count       <= ep6_count + CW'(ep6_push) - CW'(ep6_pop);
      ep6_committed   <= ep6_committed - CW'(ep6_pop) + (ep6_commit ? unc_after : '0);
      ep6_uncommitted <= ep6_commit ? '0 : unc_after;
    end
  end

  // Packet counters and sticky error bits {proto, overflow, underflow}
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
      zlp_count <= '0;
      err       <= '0;
    end else begin
      if (ep6_commit) pkt_count <= pkt_count + 16'd1;
      if (ep6_zlp)    zlp_count <= zlp_count + 8'd1;
      if (ep2_rd_req && ep2_empty) err[0] <= 1'b1;
      if (ep6_wr_req && ep6_full)  err[1] <= 1'b1;
      if (proto_err)               err[2] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fx2_fifo_responder.sv
// Scoreboard bench for fx2_fifo_responder: queues of expected EP2/EP6 words plus
// a small commit/error model, compared when the DUT presents each word.
module tb_fx2_fifo_responder;
  localparam int unsigned DEPTH     = 512;
  localparam int unsigned PKT_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        fx2_slcs_n, fx2_slrd_n, fx2_slwr_n, fx2_sloe_n, fx2_pktend_n;
  logic [1:0]  fx2_a;
  logic [15:0] fx2_db_in;
  logic [15:0] fx2_db_out;
  logic        fx2_db_oe, fx2_flaga, fx2_flagb, fx2_flagc, fx2_flagd;
  logic        host_out_valid, host_out_ready;
  logic [15:0] host_out_data;
  logic        host_in_valid, host_in_ready;
  logic [15:0] host_in_data;
  logic [15:0] pkt_count;
  logic [7:0]  zlp_count;
  logic [2:0]  err;

  int vec  = 0;
  int miss = 0;

  logic [15:0] ep2_q[$];
  logic [15:0] ep6_q[$];
  int          exp_ep2_cnt;
  int          exp_ep6_cnt;
  int          exp_unc;
  int          exp_com;
  logic [15:0] exp_pkt;
  logic [7:0]  exp_zlp;
  logic [2:0]  exp_err;

  fx2_fifo_responder #(.DEPTH(DEPTH), .PKT_WORDS(PKT_WORDS)) dut (
    .clk(clk), .rst(rst),
    .fx2_slcs_n(fx2_slcs_n), .fx2_slrd_n(fx2_slrd_n), .fx2_slwr_n(fx2_slwr_n),
    .fx2_sloe_n(fx2_sloe_n), .fx2_pktend_n(fx2_pktend_n), .fx2_a(fx2_a),
    .fx2_db_in(fx2_db_in), .fx2_db_out(fx2_db_out), .fx2_db_oe(fx2_db_oe),
    .fx2_flaga(fx2_flaga), .fx2_flagb(fx2_flagb), .fx2_flagc(fx2_flagc), .fx2_flagd(fx2_flagd),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready), .host_out_data(host_out_data),
    .host_in_valid(host_in_valid), .host_in_ready(host_in_ready), .host_in_data(host_in_data),
    .pkt_count(pkt_count), .zlp_count(zlp_count), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    fx2_slcs_n = 1'b1; fx2_slrd_n = 1'b1; fx2_slwr_n = 1'b1;
    fx2_sloe_n = 1'b1; fx2_pktend_n = 1'b1; fx2_a = 2'b00;
    host_out_valid = 1'b0; host_in_ready = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    vec++; if (fx2_flaga !== (exp_ep2_cnt != 0)) begin miss++; $display("FAIL %s flaga got %b exp %b", tag, fx2_flaga, exp_ep2_cnt != 0); end
    vec++; if (fx2_flagb !== (exp_ep6_cnt != DEPTH)) begin miss++; $display("FAIL %s flagb got %b exp %b", tag, fx2_flagb, exp_ep6_cnt != DEPTH); end
    vec++; if (fx2_flagc !== (exp_ep2_cnt != DEPTH)) begin miss++; $display("FAIL %s flagc got %b exp %b", tag, fx2_flagc, exp_ep2_cnt != DEPTH); end
    vec++; if (fx2_flagd !== (exp_ep6_cnt != 0)) begin miss++; $display("FAIL %s flagd got %b exp %b", tag, fx2_flagd, exp_ep6_cnt != 0); end
    vec++; if (host_in_valid !== (exp_com != 0)) begin miss++; $display("FAIL %s host_in_valid got %b exp %b", tag, host_in_valid, exp_com != 0); end
    vec++; if (pkt_count !== exp_pkt) begin miss++; $display("FAIL %s pkt_count got %0d exp %0d", tag, pkt_count, exp_pkt); end
    vec++; if (zlp_count !== exp_zlp) begin miss++; $display("FAIL %s zlp_count got %0d exp %0d", tag, zlp_count, exp_zlp); end
    vec++; if (err !== exp_err) begin miss++; $display("FAIL %s err got %b exp %b", tag, err, exp_err); end
  endtask

  task automatic push_ep2(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      host_out_valid = 1'b1;
      host_out_data  = base + 16'(i);
      #1;
      vec++; if (host_out_ready !== (exp_ep2_cnt < DEPTH)) begin miss++; $display("FAIL push_ready got %b exp %b", host_out_ready, exp_ep2_cnt < DEPTH); end
      if (exp_ep2_cnt < DEPTH) begin ep2_q.push_back(host_out_data); exp_ep2_cnt++; end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic read_ep2(input int n);
    logic [15:0] e;
    @(negedge clk);
    fx2_slcs_n = 1'b0; fx2_slrd_n = 1'b0; fx2_sloe_n = 1'b0; fx2_a = 2'b00;
    for (int i = 0; i < n; i++) begin
      #1;
      e = (ep2_q.size() != 0) ? ep2_q.pop_front() : 16'h0000;
      vec++; if (fx2_db_out !== e) begin miss++; $display("FAIL ep2_read[%0d] db_out got %h exp %h", i, fx2_db_out, e); end
      vec++; if (fx2_db_oe !== 1'b1) begin miss++; $display("FAIL ep2_read db_oe got %b exp 1", fx2_db_oe); end
      if (exp_ep2_cnt > 0) exp_ep2_cnt--; else exp_err[0] = 1'b1;
      @(negedge clk);
    end
    idle();
  endtask

  // Model of one EP6 edge: store, then commit or count a ZLP
  task automatic model_ep6(input logic wr, input logic pe, input logic [15:0] d);
    if (wr) begin
      if (exp_ep6_cnt < DEPTH) begin ep6_q.push_back(d); exp_ep6_cnt++; exp_unc++; end
      else exp_err[1] = 1'b1;
    end
    if ((pe && exp_unc > 0) || exp_unc == PKT_WORDS) begin
      exp_com += exp_unc; exp_unc = 0; exp_pkt++;
    end else if (pe) begin
      exp_zlp++;
    end
  endtask

  task automatic write_ep6(input int n, input logic pe_last, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fx2_slcs_n = 1'b0; fx2_slwr_n = 1'b0; fx2_a = 2'b10;
      fx2_db_in = base + 16'(i);
      fx2_pktend_n = !(pe_last && i == n - 1);
      model_ep6(1'b1, !fx2_pktend_n, fx2_db_in);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic drain_ep6(input int n_exp, input int max_words);
    int got = 0;
    logic [15:0] e;
    for (int i = 0; i < max_words + 4 && got < max_words; i++) begin
      @(negedge clk);
      host_in_ready = 1'b1;
      #1;
      if (!host_in_valid) break;
      e = (ep6_q.size() != 0) ? ep6_q.pop_front() : 16'h0000;
      vec++; if (host_in_data !== e) begin miss++; $display("FAIL ep6_drain[%0d] data got %h exp %h", got, host_in_data, e); end
      got++; exp_ep6_cnt--; exp_com--;
    end
    @(negedge clk);
    idle();
    vec++; if (got != n_exp) begin miss++; $display("FAIL ep6_drain count got %0d exp %0d", got, n_exp); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    fx2_slcs_n = 1'b0; fx2_sloe_n = 1'b0; fx2_a = 2'b00;
    @(negedge clk);
    #1;
    vec++; if (fx2_db_oe !== 1'b1) begin miss++; $display("FAIL reset db_oe got %b exp 1", fx2_db_oe); end
    @(negedge clk);
    idle();
    rst = 1'b0;
    ep2_q.delete(); ep6_q.delete();
    exp_ep2_cnt = 0; exp_ep6_cnt = 0; exp_unc = 0; exp_com = 0;
    exp_pkt = '0; exp_zlp = '0; exp_err = '0;
    #1;
    check_flags("reset");
    vec++; if (fx2_db_out !== 16'h0000) begin miss++; $display("FAIL reset db_out got %h exp 0000", fx2_db_out); end
    vec++; if (host_out_ready !== 1'b1) begin miss++; $display("FAIL reset host_out_ready got %b exp 1", host_out_ready); end
    vec++; if (fx2_db_oe !== 1'b0) begin miss++; $display("FAIL reset db_oe_idle got %b exp 0", fx2_db_oe); end
  endtask

  task automatic test_underflow();
    read_ep2(1);
    #1;
    check_flags("underflow");
    vec++; if (fx2_db_out !== 16'h0000) begin miss++; $display("FAIL underflow db_out got %h exp 0000", fx2_db_out); end
  endtask

  task automatic test_ep2_read();
    @(negedge clk); host_out_valid = 1'b1; host_out_data = 16'h1111; ep2_q.push_back(16'h1111); exp_ep2_cnt++;
    @(negedge clk); host_out_data = 16'h2222; ep2_q.push_back(16'h2222); exp_ep2_cnt++;
    @(negedge clk); host_out_data = 16'h3333; ep2_q.push_back(16'h3333); exp_ep2_cnt++;
    @(negedge clk); idle();
    #1; check_flags("ep2_loaded");
    read_ep2(3);
    #1; check_flags("ep2_drained");
  endtask

  task automatic test_ep6_packet();
    write_ep6(5, 1'b1, 16'hA000);
    #1; check_flags("ep6_pkt");
    drain_ep6(5, 5);
    #1; check_flags("ep6_pkt_drained");
  endtask

  task automatic test_auto_commit();
    write_ep6(PKT_WORDS, 1'b0, 16'h4000);
    #1; check_flags("auto_commit");
    @(negedge clk);
    fx2_slcs_n = 1'b0; fx2_pktend_n = 1'b0; fx2_a = 2'b10;
    model_ep6(1'b0, 1'b1, 16'h0000);
    @(negedge clk); idle();
    #1; check_flags("zlp");
    drain_ep6(PKT_WORDS, PKT_WORDS);
    #1; check_flags("auto_drained");
  endtask

  task automatic test_proto();
    @(negedge clk); fx2_slcs_n = 1'b0; fx2_slwr_n = 1'b0; fx2_a = 2'b00; fx2_db_in = 16'hDEAD;
    @(negedge clk); fx2_slwr_n = 1'b1; fx2_slrd_n = 1'b0; fx2_a = 2'b10;
    @(negedge clk); fx2_slrd_n = 1'b1; fx2_slwr_n = 1'b0; fx2_pktend_n = 1'b0; fx2_a = 2'b01;
    @(negedge clk); idle();
    exp_err[2] = 1'b1;
    #1; check_flags("proto");
  endtask

  task automatic test_ep2_full();
    logic [15:0] e;
    push_ep2(DEPTH, 16'h8000);
    #1; check_flags("ep2_full");
    vec++; if (host_out_ready !== 1'b0) begin miss++; $display("FAIL ep2_full ready got %b exp 0", host_out_ready); end
    read_ep2(1);
    // Push and pop on the same edge at DEPTH-1
    @(negedge clk);
    #1;
    vec++; if (host_out_ready !== 1'b1) begin miss++; $display("FAIL ep2_m1 ready got %b exp 1", host_out_ready); end
    fx2_slcs_n = 1'b0; fx2_slrd_n = 1'b0; fx2_a = 2'b00;
    host_out_valid = 1'b1; host_out_data = 16'hBEEF;
    e = ep2_q.pop_front();
    vec++; if (fx2_db_out !== e) begin miss++; $display("FAIL ep2_simul db_out got %h exp %h", fx2_db_out, e); end
    ep2_q.push_back(16'hBEEF);
    @(negedge clk); idle();
    #1; check_flags("ep2_simul");
    vec++; if (host_out_ready !== 1'b1) begin miss++; $display("FAIL ep2_simul ready got %b exp 1", host_out_ready); end
    push_ep2(1, 16'hC0DE);
    #1; check_flags("ep2_refull");
    read_ep2(DEPTH);
    #1; check_flags("ep2_emptied");
  endtask

  task automatic test_ep6_overflow();
    write_ep6(DEPTH + 1, 1'b0, 16'h2000);
    #1; check_flags("ep6_overflow");
    drain_ep6(3, 3);
    #1; check_flags("ep6_partial");
    write_ep6(2, 1'b0, 16'h7700);
    #1; check_flags("ep6_midpkt");
    test_reset();
  endtask

  initial begin
    rst = 1'b1;
    fx2_db_in = '0; host_out_data = '0;
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_underflow();
    test_ep2_read();
    test_ep6_packet();
    test_auto_commit();
    test_proto();
    test_ep2_full();
    test_ep6_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
